// File: rtl/sync_fifo_prog_if.sv
// Write/read handshake, programmable thresholds and status bundle for sync_fifo_prog.
interface sync_fifo_prog_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  rd_en;
    logic [CNT_W-1:0]      af_thresh;
    logic [CNT_W-1:0]      ae_thresh;

    logic                  full;
    logic                  almost_full;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  empty;
    logic                  almost_empty;
    logic                  rd_ack;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] dout;
    logic [CNT_W-1:0]      count;

    modport master (
        output din, wr_en, rd_en, af_thresh, ae_thresh,
        input  full, almost_full, wr_ack, wr_err, empty, almost_empty,
        input  rd_ack, rd_err, dout, count
    );

    modport slave (
        input  din, wr_en, rd_en, af_thresh, ae_thresh,
        output full, almost_full, wr_ack, wr_err, empty, almost_empty,
        output rd_ack, rd_err, dout, count
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// an occupancy count and an optional first-word-fall-through read mode.
module sync_fifo_prog #(
    parameter int unsigned  DATA_WIDTH = 8,
    parameter int unsigned  DEPTH      = 16,
    parameter int unsigned  FWFT       = 0,
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             clear_n,
    sync_fifo_prog_if.slave bus_io
);
    localparam int unsigned      AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DepthM1  = CNT_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic                  wr_accept;
    logic                  rd_accept;
    logic [CNT_W-1:0]      eff_af;
    logic [CNT_W-1:0]      eff_ae;

    always_comb begin
        // Acceptance uses the registered flags, so a full FIFO rejects a write
        // even when a read frees a slot in the same cycle (and vice versa).
        wr_accept = bus_io.wr_en && !full_q;
        rd_accept = bus_io.rd_en && !empty_q;

        wr_ptr_d = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_accept ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus_io.af_thresh == '0 || bus_io.af_thresh > DepthCnt) begin
            eff_af = DepthCnt;
        end else begin
            eff_af = bus_io.af_thresh;
        end
        eff_ae = (bus_io.ae_thresh > DepthM1) ? DepthM1 : bus_io.ae_thresh;

        full_d  = (count_d == DepthCnt);
        empty_d = (count_d == '0);
        af_d    = (count_d >= eff_af);
        ae_d    = (count_d <= eff_ae);

        wr_ack_d = wr_accept;
        wr_err_d = bus_io.wr_en && full_q;
        rd_ack_d = rd_accept;
        rd_err_d = bus_io.rd_en && empty_q;

        dout_d = dout_q;
        if (FWFT != 0) begin
            // Present the next head; bypass din when the head is the word written this edge.
            if (count_d != '0) begin
                if (wr_accept && (wr_ptr_q == rd_ptr_d)) begin
                    dout_d = bus_io.din;
                end else begin
                    dout_d = mem_q[rd_ptr_d];
                end
            end
        end else if (rd_accept) begin
            dout_d = mem_q[rd_ptr_q];
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus_io.din;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
            dout_q   <= dout_d;
        end
    end

    assign bus_io.full         = full_q;
    assign bus_io.almost_full  = af_q;
    assign bus_io.wr_ack       = wr_ack_q;
    assign bus_io.wr_err       = wr_err_q;
    assign bus_io.empty        = empty_q;
    assign bus_io.almost_empty = ae_q;
    assign bus_io.rd_ack       = rd_ack_q;
    assign bus_io.rd_err       = rd_err_q;
    assign bus_io.dout         = dout_q;
    assign bus_io.count        = count_q;

    ack_err_excl_a: assert property (@(posedge clk) disable iff (!clear_n)
        !(wr_ack_q && wr_err_q) && !(rd_ack_q && rd_err_q));
    count_range_a: assert property (@(posedge clk) disable iff (!clear_n)
        count_q <= DepthCnt);
    flags_excl_a: assert property (@(posedge clk) disable iff (!clear_n)
        !(full_q && empty_q));
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: vector table for fill/drain plus hand sequences.
module tb_sync_fifo_prog;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic clk     = 1'b0;
    logic clear_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) f0 ();
    sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) f1 ();

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk     (clk),
        .clear_n (clear_n),
        .bus_io  (f0)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk     (clk),
        .clear_n (clear_n),
        .bus_io  (f1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       wack;
        logic       werr;
        logic       rack;
        logic       rerr;
        logic       dchk;
        logic [7:0] dout;
    } vec_t;

    vec_t       vecs[64];
    int         nvec = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic wr, input logic rd, input logic [7:0] din,
                           input int cnt, input logic full, input logic empty,
                           input logic af, input logic ae, input logic wack,
                           input logic werr, input logic rack, input logic rerr,
                           input logic dchk, input logic [7:0] dout);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.cnt = 5'(cnt);
        v.full = full; v.empty = empty; v.af = af; v.ae = ae;
        v.wack = wack; v.werr = werr; v.rack = rack; v.rerr = rerr;
        v.dchk = dchk; v.dout = dout;
        vecs[nvec] = v;
        nvec++;
    endtask

    task automatic step0(input logic w, input logic r, input logic [7:0] d);
        f0.wr_en = w;
        f0.rd_en = r;
        f0.din   = d;
        @(posedge clk);
        #1;
        f0.wr_en = 1'b0;
        f0.rd_en = 1'b0;
    endtask

    task automatic step1(input logic w, input logic r, input logic [7:0] d);
        f1.wr_en = w;
        f1.rd_en = r;
        f1.din   = d;
        @(posedge clk);
        #1;
        f1.wr_en = 1'b0;
        f1.rd_en = 1'b0;
    endtask

    task automatic rst_chk0(input string tag);
        chk({tag, " count"}, 32'(f0.count), 0);
        chk({tag, " empty"}, 32'(f0.empty), 1);
        chk({tag, " almost_empty"}, 32'(f0.almost_empty), 1);
        chk({tag, " full"}, 32'(f0.full), 0);
        chk({tag, " almost_full"}, 32'(f0.almost_full), 0);
        chk({tag, " ack/err"}, 32'({f0.wr_ack, f0.wr_err, f0.rd_ack, f0.rd_err}), 0);
        chk({tag, " dout"}, 32'(f0.dout), 0);
        chk({tag, " fwft empty"}, 32'(f1.empty), 1);
        chk({tag, " fwft dout"}, 32'(f1.dout), 0);
    endtask

    initial begin
        f0.wr_en = 1'b0; f0.rd_en = 1'b0; f0.din = '0;
        f0.af_thresh = 5'd12; f0.ae_thresh = 5'd3;
        f1.wr_en = 1'b0; f1.rd_en = 1'b0; f1.din = '0;
        f1.af_thresh = 5'd12; f1.ae_thresh = 5'd3;

        // Fill/drain table: flags follow count with af_thresh = 12, ae_thresh = 3.
        for (int i = 0; i < 16; i++) begin
            add_vec(1, 0, 8'(i), i + 1, i == 15, 0, (i + 1) >= 12, (i + 1) <= 3,
                    1, 0, 0, 0, 0, 8'h00);
        end
        add_vec(1, 0, 8'hFF, 16, 1, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00);
        add_vec(1, 1, 8'hEE, 15, 0, 0, 1, 0, 0, 1, 1, 0, 1, 8'h00);
        for (int k = 1; k < 16; k++) begin
            add_vec(0, 1, 8'h00, 15 - k, 0, (15 - k) == 0, (15 - k) >= 12, (15 - k) <= 3,
                    0, 0, 1, 0, 1, 8'(k));
        end
        add_vec(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 8'h0F);

        #1 clear_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_chk0("reset");
        @(posedge clk);
        #2 clear_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            step0(vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk($sformatf("vec%0d count", i), 32'(f0.count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d full", i), 32'(f0.full), 32'(vecs[i].full));
            chk($sformatf("vec%0d empty", i), 32'(f0.empty), 32'(vecs[i].empty));
            chk($sformatf("vec%0d almost_full", i), 32'(f0.almost_full), 32'(vecs[i].af));
            chk($sformatf("vec%0d almost_empty", i), 32'(f0.almost_empty), 32'(vecs[i].ae));
            chk($sformatf("vec%0d wr_ack", i), 32'(f0.wr_ack), 32'(vecs[i].wack));
            chk($sformatf("vec%0d wr_err", i), 32'(f0.wr_err), 32'(vecs[i].werr));
            chk($sformatf("vec%0d rd_ack", i), 32'(f0.rd_ack), 32'(vecs[i].rack));
            chk($sformatf("vec%0d rd_err", i), 32'(f0.rd_err), 32'(vecs[i].rerr));
            if (vecs[i].dchk) begin
                chk($sformatf("vec%0d dout", i), 32'(f0.dout), 32'(vecs[i].dout));
            end
        end

        // Wrap-around: pointers move to 10, then 12 entries cross the end of the array.
        for (int i = 0; i < 10; i++) begin
            step0(1, 0, 8'(8'h30 + i));
            exp_q.push_back(8'(8'h30 + i));
        end
        for (int i = 0; i < 10; i++) begin
            step0(0, 1, 8'h00);
            chk($sformatf("wrap1 dout%0d", i), 32'(f0.dout), 32'(exp_q.pop_front()));
        end
        for (int i = 0; i < 12; i++) begin
            step0(1, 0, 8'(8'h60 + i));
            exp_q.push_back(8'(8'h60 + i));
        end
        chk("wrap peak count", 32'(f0.count), 12);
        chk("wrap peak almost_full", 32'(f0.almost_full), 1);
        for (int i = 0; i < 12; i++) begin
            step0(0, 1, 8'h00);
            chk($sformatf("wrap2 dout%0d", i), 32'(f0.dout), 32'(exp_q.pop_front()));
            chk($sformatf("wrap2 rd_ack%0d", i), 32'(f0.rd_ack), 1);
        end
        chk("wrap empty", 32'(f0.empty), 1);

        // Simultaneous accepted read and write at count 8.
        for (int i = 0; i < 8; i++) begin
            step0(1, 0, 8'(8'h80 + i));
            exp_q.push_back(8'(8'h80 + i));
        end
        step0(1, 1, 8'h99);
        exp_q.push_back(8'h99);
        chk("simul count", 32'(f0.count), 8);
        chk("simul acks", 32'({f0.wr_ack, f0.wr_err, f0.rd_ack, f0.rd_err}), 32'b1010);
        chk("simul dout", 32'(f0.dout), 32'(exp_q.pop_front()));
        for (int i = 0; i < 8; i++) begin
            step0(0, 1, 8'h00);
            chk($sformatf("simul drain dout%0d", i), 32'(f0.dout), 32'(exp_q.pop_front()));
        end
        chk("simul drained", 32'(f0.count), 0);

        // af_thresh = 0 makes almost_full track full; out-of-range thresholds saturate.
        f0.af_thresh = 5'd0;
        for (int i = 0; i < 16; i++) begin
            step0(1, 0, 8'(i));
            chk($sformatf("af0 almost_full%0d", i), 32'(f0.almost_full), 32'(i == 15));
        end
        f0.af_thresh = 5'd20;
        f0.ae_thresh = 5'd31;
        step0(0, 0, 8'h00);
        chk("af20 almost_full", 32'(f0.almost_full), 1);
        chk("ae31 at 16", 32'(f0.almost_empty), 0);
        f0.af_thresh = 5'd16;
        step0(0, 1, 8'h00);
        chk("af16 at 15", 32'(f0.almost_full), 0);
        chk("ae31 at 15", 32'(f0.almost_empty), 1);
        for (int i = 0; i < 15; i++) step0(0, 1, 8'h00);
        chk("af0 drained", 32'(f0.empty), 1);
        f0.af_thresh = 5'd12;
        f0.ae_thresh = 5'd3;

        // Asynchronous reset mid-cycle with 5 entries held.
        for (int i = 0; i < 6; i++) step0(1, 0, 8'(8'h51 + i));
        step0(0, 1, 8'h00);
        chk("pre-reset count", 32'(f0.count), 5);
        chk("pre-reset dout", 32'(f0.dout), 32'h51);
        #2 clear_n = 1'b0;
        #1;
        rst_chk0("mid reset");
        @(posedge clk);
        #2 clear_n = 1'b1;
        step0(1, 0, 8'h77);
        step0(0, 1, 8'h00);
        chk("post-reset dout", 32'(f0.dout), 32'h77);
        chk("post-reset count", 32'(f0.count), 0);

        // FWFT: head appears without rd_en; pops expose the next word.
        step1(1, 0, 8'hA5);
        chk("fwft dout A5", 32'(f1.dout), 32'hA5);
        chk("fwft not empty", 32'(f1.empty), 0);
        chk("fwft no rd_ack", 32'(f1.rd_ack), 0);
        step1(0, 1, 8'h00);
        chk("fwft pop empty", 32'(f1.empty), 1);
        chk("fwft pop rd_ack", 32'(f1.rd_ack), 1);
        chk("fwft hold dout", 32'(f1.dout), 32'hA5);
        step1(1, 0, 8'h11);
        step1(1, 0, 8'h22);
        chk("fwft head 11", 32'(f1.dout), 32'h11);
        step1(0, 1, 8'h00);
        chk("fwft head 22", 32'(f1.dout), 32'h22);
        step1(1, 1, 8'h44);
        chk("fwft bypass dout", 32'(f1.dout), 32'h44);
        chk("fwft bypass count", 32'(f1.count), 1);
        chk("fwft bypass acks", 32'({f1.wr_ack, f1.rd_ack}), 32'b11);
        step1(0, 1, 8'h00);
        step1(0, 1, 8'h00);
        chk("fwft rd_err", 32'(f1.rd_err), 1);
        chk("fwft empty dout", 32'(f1.dout), 32'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
